// File: rtl/ucode_seq.sv
// Micro-code sequencer: expands one macro-instruction into a per-cycle stream
// of ALU micro-instructions plus register-file and immediate bus strobes.
module ucode_seq #(
    parameter int STEP_W = 3
) (
    input  logic       clk,
    input  logic       grst,
    input  logic       start,
    output logic       ready,
    input  logic [3:0] mop,
    input  logic [1:0] ra,
    input  logic [1:0] rb,
    input  logic [1:0] rd,
    input  logic       stall,
    output logic [3:0] alu_instr,
    output logic       rf_oe,
    output logic [1:0] rf_rsel,
    output logic       rf_we,
    output logic [1:0] rf_wsel,
    output logic       imm_oe,
    output logic [3:0] imm,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] I_NOP  = 4'h0;
    localparam logic [3:0] I_LDA  = 4'h1;
    localparam logic [3:0] I_LDB  = 4'h2;
    localparam logic [3:0] I_LDOP = 4'h3;
    localparam logic [3:0] I_EXE  = 4'h4;
    localparam logic [3:0] I_RDR  = 4'h5;
    localparam logic [3:0] I_RDF  = 4'h6;
    localparam logic [3:0] I_LRST = 4'hF;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [STEP_W-1:0] step, step_nxt, issue_step, seq_len;
    logic [3:0]        mop_q, cur_mop;
    logic [1:0]        ra_q, rb_q, rd_q, cur_ra, cur_rb, cur_rd;
    logic              issue;

    logic [3:0] alu_d, imm_d;
    logic       rf_oe_d, rf_we_d, imm_oe_d, done_d, err_d;
    logic [1:0] rsel_d, wsel_d;

    assign ready = (state == IDLE);

    // step holds the index of the next step to issue; outputs are registered,
    // so the step being issued is decoded one edge ahead of its cycle.
    always_comb begin
        state_nxt  = state;
        step_nxt   = step;
        issue      = 1'b0;
        issue_step = step;
        cur_mop    = mop_q;
        cur_ra     = ra_q;
        cur_rb     = rb_q;
        cur_rd     = rd_q;
        case (state)
            IDLE: begin
                cur_mop = mop;
                cur_ra  = ra;
                cur_rb  = rb;
                cur_rd  = rd;
                if (start) begin
                    issue      = 1'b1;
                    issue_step = '0;
                    step_nxt   = STEP_W'(1);
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (step == seq_len) begin
                        state_nxt = IDLE;
                        step_nxt  = '0;
                    end else begin
                        issue    = 1'b1;
                        step_nxt = step + STEP_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign seq_len = (cur_mop >= 4'h1 && cur_mop <= 4'h7) ? STEP_W'(5) : STEP_W'(1);

    always_comb begin
        alu_d    = I_NOP;
        rf_oe_d  = 1'b0;
        rsel_d   = 2'd0;
        rf_we_d  = 1'b0;
        wsel_d   = 2'd0;
        imm_oe_d = 1'b0;
        imm_d    = 4'h0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (issue) begin
            case (cur_mop)
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                    case (int'(issue_step))
                        0: begin rf_oe_d = 1'b1; rsel_d = cur_ra; alu_d = I_LDA; end
                        1: begin rf_oe_d = 1'b1; rsel_d = cur_rb; alu_d = I_LDB; end
                        2: begin imm_oe_d = 1'b1; imm_d = cur_mop; alu_d = I_LDOP; end
                        3: alu_d = I_EXE;
                        4: begin
                            alu_d   = I_RDR;
                            rf_we_d = 1'b1;
                            wsel_d  = cur_rd;
                            done_d  = 1'b1;
                        end
                        default: alu_d = I_NOP;
                    endcase
                end
                4'h8: begin
                    rf_oe_d = 1'b1;
                    rsel_d  = cur_ra;
                    rf_we_d = 1'b1;
                    wsel_d  = cur_rd;
                    done_d  = 1'b1;
                end
                4'h9: begin
                    alu_d   = I_RDF;
                    rf_we_d = 1'b1;
                    wsel_d  = cur_rd;
                    done_d  = 1'b1;
                end
                4'hA: begin
                    alu_d  = I_LRST;
                    done_d = 1'b1;
                end
                4'h0: done_d = 1'b1;
                default: begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (grst) begin
            state     <= IDLE;
            step      <= '0;
            mop_q     <= 4'h0;
            ra_q      <= 2'd0;
            rb_q      <= 2'd0;
            rd_q      <= 2'd0;
            alu_instr <= I_NOP;
            rf_oe     <= 1'b0;
            rf_rsel   <= 2'd0;
            rf_we     <= 1'b0;
            rf_wsel   <= 2'd0;
            imm_oe    <= 1'b0;
            imm       <= 4'h0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            if (state == IDLE && start) begin
                mop_q <= mop;
                ra_q  <= ra;
                rb_q  <= rb;
                rd_q  <= rd;
            end
            alu_instr <= alu_d;
            rf_oe     <= rf_oe_d;
            rf_rsel   <= rsel_d;
            rf_we     <= rf_we_d;
            rf_wsel   <= wsel_d;
            imm_oe    <= imm_oe_d;
            imm       <= imm_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_ucode_seq.sv
// Scoreboard bench for ucode_seq: each accepted macro-instruction pushes its
// expected per-cycle output vectors, which are popped and compared every cycle.
module tb_ucode_seq;

    typedef struct packed {
        logic       rdy;
        logic [3:0] alu;
        logic       oe;
        logic [1:0] rsel;
        logic       we;
        logic [1:0] wsel;
        logic       ioe;
        logic [3:0] iv;
        logic       dn;
        logic       er;
    } outv_t;

    logic       clk = 1'b0;
    logic       grst, start, stall;
    logic [3:0] mop;
    logic [1:0] ra, rb, rd;
    logic       ready, rf_oe, rf_we, imm_oe, done, err;
    logic [3:0] alu_instr, imm;
    logic [1:0] rf_rsel, rf_wsel;

    int    tests_run    = 0;
    int    tests_failed = 0;
    bit    mon_en       = 1'b0;
    int    bus_users;
    outv_t exp_q[$];

    ucode_seq dut (
        .clk(clk), .grst(grst), .start(start), .ready(ready),
        .mop(mop), .ra(ra), .rb(rb), .rd(rd), .stall(stall),
        .alu_instr(alu_instr), .rf_oe(rf_oe), .rf_rsel(rf_rsel),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .imm_oe(imm_oe), .imm(imm),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Shared-bus exclusivity is checked every cycle, independent of the scenarios.
    always @(negedge clk) begin
        if (mon_en) begin
            bus_users = int'(rf_oe) + int'(imm_oe) + int'(alu_instr == 4'h5 || alu_instr == 4'h6);
            tests_run++;
            if (bus_users > 1) begin
                tests_failed++;
                $display("[TB] FAIL bus_exclusive t=%0t: %0d drivers, required at most 1", $time, bus_users);
            end
        end
    end

    function automatic outv_t idle_v(input logic r);
        outv_t e = '0;
        e.rdy = r;
        return e;
    endfunction

    function automatic int op_len(input logic [3:0] m);
        return (m >= 4'h1 && m <= 4'h7) ? 5 : 1;
    endfunction

    function automatic outv_t exp_step(input logic [3:0] m, input logic [1:0] a, b, d, input int s);
        outv_t e = '0;
        if (m >= 4'h1 && m <= 4'h7) begin
            case (s)
                0: begin e.oe = 1'b1; e.rsel = a; e.alu = 4'h1; end
                1: begin e.oe = 1'b1; e.rsel = b; e.alu = 4'h2; end
                2: begin e.ioe = 1'b1; e.iv = m; e.alu = 4'h3; end
                3: e.alu = 4'h4;
                default: begin e.alu = 4'h5; e.we = 1'b1; e.wsel = d; e.dn = 1'b1; end
            endcase
        end else if (m == 4'h8) begin
            e.oe = 1'b1; e.rsel = a; e.we = 1'b1; e.wsel = d; e.dn = 1'b1;
        end else if (m == 4'h9) begin
            e.alu = 4'h6; e.we = 1'b1; e.wsel = d; e.dn = 1'b1;
        end else if (m == 4'hA) begin
            e.alu = 4'hF; e.dn = 1'b1;
        end else if (m == 4'h0) begin
            e.dn = 1'b1;
        end else begin
            e.dn = 1'b1; e.er = 1'b1;
        end
        return e;
    endfunction

    task automatic push_op(input logic [3:0] m, input logic [1:0] a, b, d);
        for (int s = 0; s < op_len(m); s++) exp_q.push_back(exp_step(m, a, b, d, s));
    endtask

    task automatic push_idle(input logic r, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(idle_v(r));
    endtask

    task automatic drive_start(input logic [3:0] m, input logic [1:0] a, b, d);
        start = 1'b1; mop = m; ra = a; rb = b; rd = d;
    endtask

    // Advance one clock and return the observed and scheduled output vectors.
    task automatic tick(output outv_t act, output outv_t exp);
        @(posedge clk);
        #1;
        act = {ready, alu_instr, rf_oe, rf_rsel, rf_we, rf_wsel, imm_oe, imm, done, err};
        if (exp_q.size() == 0) exp = '1;
        else exp = exp_q.pop_front();
    endtask

    task automatic test_reset();
        outv_t act, exp;
        grst = 1'b1; start = 1'b0; stall = 1'b0;
        mop = 4'h0; ra = 2'd0; rb = 2'd0; rd = 2'd0;
        push_idle(1'b1, 12);
        for (int i = 0; i < 12; i++) begin
            tick(act, exp);
            if (i == 0) mon_en = 1'b1;
            if (i == 1) grst = 1'b0;
            tests_run++;
            if (act !== exp) begin
                tests_failed++;
                $display("[TB] FAIL reset_idle c%0d: got %h required %h", i, act, exp);
            end
        end
    endtask

    task automatic test_add();
        outv_t act, exp;
        drive_start(4'h2, 2'd1, 2'd3, 2'd2);
        push_op(4'h2, 2'd1, 2'd3, 2'd2);
        push_idle(1'b1, 1);
        for (int i = 0; i < 6; i++) begin
            tick(act, exp);
            if (i == 0) begin
                start = 1'b0; mop = 4'hE; ra = 2'd0; rb = 2'd0; rd = 2'd0;
            end
            tests_run++;
            if (act !== exp) begin
                tests_failed++;
                $display("[TB] FAIL add c%0d: got %h required %h", i, act, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        outv_t act, exp;
        drive_start(4'h8, 2'd0, 2'd1, 2'd3);
        push_op(4'h8, 2'd0, 2'd1, 2'd3);
        push_idle(1'b1, 1);
        push_op(4'h9, 2'd2, 2'd1, 2'd3);
        push_idle(1'b1, 1);
        for (int i = 0; i < 4; i++) begin
            tick(act, exp);
            if (i == 0) begin mop = 4'h9; ra = 2'd2; end
            if (i == 2) start = 1'b0;
            tests_run++;
            if (act !== exp) begin
                tests_failed++;
                $display("[TB] FAIL b2b_mov_flg c%0d: got %h required %h", i, act, exp);
            end
        end
        drive_start(4'h3, 2'd2, 2'd1, 2'd0);
        push_op(4'h3, 2'd2, 2'd1, 2'd0);
        push_idle(1'b1, 3);
        for (int i = 0; i < 8; i++) begin
            tick(act, exp);
            if (i == 0) start = 1'b0;
            if (i == 2) begin start = 1'b1; mop = 4'hA; end
            if (i == 3) start = 1'b0;
            tests_run++;
            if (act !== exp) begin
                tests_failed++;
                $display("[TB] FAIL b2b_busy_start c%0d: got %h required %h", i, act, exp);
            end
        end
    endtask

    task automatic test_stall();
        outv_t act, exp;
        drive_start(4'h5, 2'd2, 2'd0, 2'd1);
        for (int s = 0; s < 2; s++) exp_q.push_back(exp_step(4'h5, 2'd2, 2'd0, 2'd1, s));
        push_idle(1'b0, 3);
        for (int s = 2; s < 5; s++) exp_q.push_back(exp_step(4'h5, 2'd2, 2'd0, 2'd1, s));
        push_idle(1'b1, 4);
        for (int i = 0; i < 12; i++) begin
            tick(act, exp);
            if (i == 0) start = 1'b0;
            if (i == 1) stall = 1'b1;
            if (i == 4) stall = 1'b0;
            if (i == 8) stall = 1'b1;
            if (i == 11) stall = 1'b0;
            tests_run++;
            if (act !== exp) begin
                tests_failed++;
                $display("[TB] FAIL stall c%0d: got %h required %h", i, act, exp);
            end
        end
    endtask

    task automatic test_illegal();
        outv_t act, exp;
        drive_start(4'hC, 2'd1, 2'd1, 2'd1);
        push_op(4'hC, 2'd1, 2'd1, 2'd1);
        push_idle(1'b1, 1);
        push_op(4'hA, 2'd1, 2'd1, 2'd1);
        push_idle(1'b1, 1);
        for (int i = 0; i < 4; i++) begin
            tick(act, exp);
            if (i == 0) start = 1'b0;
            if (i == 1) begin start = 1'b1; mop = 4'hA; end
            if (i == 2) start = 1'b0;
            tests_run++;
            if (act !== exp) begin
                tests_failed++;
                $display("[TB] FAIL illegal c%0d: got %h required %h", i, act, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        outv_t act, exp;
        drive_start(4'h7, 2'd3, 2'd2, 2'd1);
        for (int s = 0; s < 4; s++) exp_q.push_back(exp_step(4'h7, 2'd3, 2'd2, 2'd1, s));
        push_idle(1'b1, 6);
        for (int i = 0; i < 10; i++) begin
            tick(act, exp);
            if (i == 0) start = 1'b0;
            if (i == 3) begin grst = 1'b1; stall = 1'b1; end
            if (i == 4) begin grst = 1'b0; stall = 1'b0; end
            tests_run++;
            if (act !== exp) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid c%0d: got %h required %h", i, act, exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ucode_seq.md
Name: ucode_seq

Overview:
- Micro-code sequencer directly upstream of the ALU unit.
- Accepts one macro-instruction per handshake: macro opcode plus register addresses.
- Expands it into a fixed per-cycle sequence of 4-bit ALU micro-instructions, plus bus-driver and register-file strobes.
- The sequence moves operands over the shared 4-bit bus into the ALU and writes the result back.

Parameters:
- STEP_W, 3, width of the internal step counter; must hold the longest sequence (5 steps).

Ports:
- clk  input  1  system clock, rising edge.
- grst  input  1  global reset; synchronous, active-high.
- start  input  1  macro-instruction valid; sampled only while ready=1.
- ready  output  1  sequencer idle and able to accept start.
- mop  input  4  macro opcode; latched on accept.
- ra  input  2  source register A index; latched on accept.
- rb  input  2  source register B index; latched on accept.
- rd  input  2  destination register index; latched on accept.
- stall  input  1  freeze sequence this cycle.
- alu_instr  output  4  micro-instruction to ALU unit.
- rf_oe  output  1  register file drives bus.
- rf_rsel  output  2  register-file read index.
- rf_we  output  1  register file captures bus.
- rf_wsel  output  2  register-file write index.
- imm_oe  output  1  immediate driver drives bus.
- imm  output  4  immediate value.
- done  output  1  one-cycle pulse: macro-instruction complete.
- err  output  1  one-cycle pulse: illegal macro opcode.

Behaviour:
- Micro-instruction codes emitted on alu_instr:
  - 0x0 NOP
  - 0x1 LDA (bus→operand A)
  - 0x2 LDB (bus→operand B)
  - 0x3 LDOP (bus→opcode)
  - 0x4 EXE (latch result and flags)
  - 0x5 RDR (result→bus)
  - 0x6 RDF (flags→bus)
  - 0xF LRST (local reset)
  - All other codes are never emitted.
- Idle output set: alu_instr=0, all strobes=0, rsel/wsel/imm=0, done=0, err=0.
- All outputs are registered except ready, which is 1 exactly when the state is IDLE.
- Reset: grst=1 at a clock edge forces state IDLE, step counter 0, all outputs to the idle set, and clears the latched fields.
  - ready=1 on the following cycle.
  - Reset mid-sequence aborts it with no done.
- State machine: IDLE, RUN.
  - IDLE: start=1 at edge T → latch mop/ra/rb/rd, go to RUN with step=0. The step 0 outputs appear at T+1.
  - start=1 while not ready is ignored and is not queued.
  - RUN: each non-stalled edge advances the step. After the last step's outputs, the next edge returns to IDLE.
- Sequences (one line per cycle; unlisted outputs are idle):
  - mop 0x1–0x7 (binary ALU op, 5 steps):
    - S0: rf_oe=1, rsel=ra, LDA
    - S1: rf_oe=1, rsel=rb, LDB
    - S2: imm_oe=1, imm=mop, LDOP
    - S3: EXE
    - S4: RDR, rf_we=1, wsel=rd, done=1
  - mop 0x8 MOV: S0: rf_oe=1, rsel=ra, rf_we=1, wsel=rd, NOP, done=1.
  - mop 0x9 FLG: S0: RDF, rf_we=1, wsel=rd, done=1.
  - mop 0xA CLR: S0: LRST, done=1.
  - mop 0x0 NOP: S0: idle outputs, done=1.
  - mop 0xB–0xF: S0: idle outputs, done=1, err=1.
- Latency: an n-step op accepted at edge T has done high during cycle T+n. ready returns during cycle T+n+1. Back-to-back: the next start is accepted at edge T+n+1.
- Stall: stall=1 in RUN holds the step. The output set for that cycle is idle (no strobes, alu_instr=NOP, no done/err), and the same step is re-issued once stall drops. stall in IDLE has no effect. grst overrides stall.
- Bus exclusivity invariant: in every cycle at most one of {rf_oe, imm_oe, alu_instr∈{RDR,RDF}} is active. The bench must check this every cycle.
- Inputs mop/ra/rb/rd may change freely after accept without affecting the running sequence.

Test Plan:
- Reset then idle: hold grst 2 cycles, release → ready=1, all outputs idle, no done for 10 cycles with start=0.
- ADD-style op: start with mop=0x2, ra=1, rb=3, rd=2 at T → alu_instr 1,2,3,4,5 on T+1..T+5.
  - rsel=1 at T+1, rsel=3 at T+2.
  - imm_oe=1 with imm=0x2 at T+3.
  - rf_we=1 with wsel=2 and done=1 at T+5.
  - ready=1 at T+6.
- Back-to-back ops:
  - Part 1: MOV ra=0, rd=3 accepted → done 1 cycle later.
  - Part 2: start held high throughout → FLG accepted at the next ready edge → RDF with wsel=3 and done.
  - Part 3: a start pulse during the busy cycles is ignored.
- Stall mid-op: stall=1 during the S2 cycle for 3 cycles → 3 idle-output cycles, then S2 re-issued with imm=mop. done is delayed by exactly 3 cycles.
- Illegal opcode: mop=0xC → done=1 and err=1 together for one cycle, no strobes. Following mop=0xA → LRST emitted, err=0.
- Reset mid-operation: assert grst at the S3 cycle of a binary op → next cycle idle, ready=1, and done never pulses for the aborted op.
